// File: rtl/stopwatch_pkg.sv
// Shared widths and run-state encodings for the stopwatch controller slice.
package stopwatch_pkg;

  localparam int CNT_W = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LAP   = 2'd3;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button-in / display-out bundle between the button front-end and the stopwatch controller.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic             btn_ss;
  logic             btn_lc;
  logic [CNT_W-1:0] disp_sec;
  logic [CNT_W-1:0] disp_min;
  logic             running;
  logic             lap_active;
  logic             wrap;

  modport master (
    output btn_ss, btn_lc,
    input  disp_sec, disp_min, running, lap_active, wrap
  );

  modport slave (
    input  btn_ss, btn_lc,
    output disp_sec, disp_min, running, lap_active, wrap
  );

endinterface

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with synchronous clear; carry flags the enabled terminal count.
module mod_counter
  import stopwatch_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             carry
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);

  assign carry = en && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= carry ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: run-state FSM, 1-second prescaler, cascaded sec/min counters and lap-freeze display.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_PER_SEC = 50_000_000,
  parameter int SEC_MOD     = 60,
  parameter int MIN_MOD     = 60
) (
  input  logic           clk,
  input  logic           reset,
  stopwatch_ctrl_if.slave bus
);

  localparam int             PRE_W   = $clog2(CLK_PER_SEC);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_SEC - 1);

  if (CLK_PER_SEC < 2 || SEC_MOD < 2 || MIN_MOD < 2 ||
      SEC_MOD > (1 << CNT_W) || MIN_MOD > (1 << CNT_W)) begin : g_bad_cfg
    $error("stopwatch_ctrl: CLK_PER_SEC must be >=2 and SEC_MOD/MIN_MOD within 2..64");
  end

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [PRE_W-1:0] presc;
  logic             counting;
  logic             sec_en;
  logic             clr;
  logic             lap_capture;
  logic [CNT_W-1:0] sec;
  logic [CNT_W-1:0] min;
  logic             sec_carry;
  logic             min_carry;
  logic [CNT_W-1:0] lap_sec;
  logic [CNT_W-1:0] lap_min;

  logic [CNT_W-1:0] disp_sec_p1;
  logic [CNT_W-1:0] disp_min_p1;
  logic             running_p1;
  logic             lap_active_p1;
  logic             wrap_p1;

  // btn_ss always takes priority; btn_lc only acts when start/stop is idle
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (bus.btn_ss) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (bus.btn_ss)      next_state = ST_PAUSE;
        else if (bus.btn_lc) next_state = ST_LAP;
      end
      ST_LAP: begin
        if (bus.btn_ss)      next_state = ST_PAUSE;
        else if (bus.btn_lc) next_state = ST_RUN;
      end
      ST_PAUSE: begin
        if (bus.btn_ss)      next_state = ST_RUN;
        else if (bus.btn_lc) next_state = ST_IDLE;
      end
      default: next_state = state;
    endcase
  end

  assign counting    = (state == ST_RUN) || (state == ST_LAP);
  assign sec_en      = counting && (presc == PRE_MAX);
  assign clr         = (state == ST_PAUSE) && !bus.btn_ss && bus.btn_lc;
  assign lap_capture = (state == ST_RUN) && !bus.btn_ss && bus.btn_lc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Prescaler holds in PAUSE so a partial second survives pause/resume
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (counting) begin
      presc <= sec_en ? '0 : presc + PRE_W'(1);
    end
  end

  mod_counter #(.MOD(SEC_MOD)) u_sec (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (sec_en),
    .count (sec),
    .carry (sec_carry)
  );

  mod_counter #(.MOD(MIN_MOD)) u_min (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (sec_carry),
    .count (min),
    .carry (min_carry)
  );

  // Latch samples the registered count, i.e. the value before any same-edge increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_sec <= '0;
      lap_min <= '0;
    end else if (lap_capture) begin
      lap_sec <= sec;
      lap_min <= min;
    end
  end

  // Output stage p1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_sec_p1   <= '0;
      disp_min_p1   <= '0;
      running_p1    <= 1'b0;
      lap_active_p1 <= 1'b0;
      wrap_p1       <= 1'b0;
    end else begin
      disp_sec_p1   <= (state == ST_LAP) ? lap_sec : sec;
      disp_min_p1   <= (state == ST_LAP) ? lap_min : min;
      running_p1    <= (next_state == ST_RUN) || (next_state == ST_LAP);
      lap_active_p1 <= (next_state == ST_LAP);
      wrap_p1       <= min_carry;
    end
  end

  assign bus.disp_sec   = disp_sec_p1;
  assign bus.disp_min   = disp_min_p1;
  assign bus.running    = running_p1;
  assign bus.lap_active = lap_active_p1;
  assign bus.wrap       = wrap_p1;

endmodule
